// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller timers: interval codes,
// timer FSM encoding and the width of a time-unit count.
package traffic_pkg;

  localparam logic [1:0] INT_BASE   = 2'b00;
  localparam logic [1:0] INT_EXT    = 2'b01;
  localparam logic [1:0] INT_YELLOW = 2'b10;
  localparam logic [1:0] INT_DOUBLE = 2'b11;

  localparam int unsigned TIME_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StSel   = 2'b01,
    StLoad  = 2'b10,
    StCount = 2'b11
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one-cycle time-unit ticks. Counts only while enabled;
// clear forces the count back to zero and suppresses any tick that cycle.
module tick_prescaler #(
  parameter int unsigned CLK_PER_TICK = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_TICK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_TICK - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_tick    = i_enable && !i_clear && w_at_last;

  // Prescale counter: wraps to zero on the tick cycle, frozen when not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Phase interval timer: presents an interval code to the time-parameter block,
// loads the returned duration and counts it down in time units, then pulses
// expired for one cycle.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        interval_sel,
  input  logic              abort,
  input  logic [TIME_W-1:0] value,
  output logic [1:0]        interval,
  output logic              busy,
  output logic              expired,
  output logic [TIME_W-1:0] remaining
);

  timer_state_e      r_state, w_state_nxt;
  logic [1:0]        r_interval, w_interval_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_expired, w_expired_nxt;
  logic [TIME_W-1:0] r_remaining, w_remaining_nxt;

  logic w_tick;
  logic w_pre_clear;
  logic w_pre_en;

  // Prescaler restarts on load and on abort, and only runs while counting.
  assign w_pre_clear = (r_state == StLoad) || abort;
  assign w_pre_en    = (r_state == StCount) && !abort;

  tick_prescaler #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_pre_clear),
    .i_enable(w_pre_en),
    .o_tick  (w_tick)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_interval  <= INT_BASE;
      r_busy      <= 1'b0;
      r_expired   <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_interval  <= w_interval_nxt;
      r_busy      <= w_busy_nxt;
      r_expired   <= w_expired_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state logic; expired defaults low so it can only ever be a single-cycle pulse.
  always_comb begin
    w_state_nxt     = r_state;
    w_interval_nxt  = r_interval;
    w_busy_nxt      = r_busy;
    w_expired_nxt   = 1'b0;
    w_remaining_nxt = r_remaining;

    unique case (r_state)
      StIdle: begin
        if (start && !abort) begin
          w_interval_nxt = interval_sel;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = StSel;
        end
      end
      // Give the time-parameter block one cycle to register value for the new code.
      StSel: begin
        w_state_nxt = StLoad;
      end
      StLoad: begin
        w_remaining_nxt = value;
        if (value == '0) begin
          w_expired_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = StIdle;
        end else begin
          w_state_nxt = StCount;
        end
      end
      StCount: begin
        if (w_tick) begin
          if (r_remaining <= TIME_W'(1)) begin
            w_remaining_nxt = '0;
            w_expired_nxt   = 1'b1;
            w_busy_nxt      = 1'b0;
            w_state_nxt     = StIdle;
          end else begin
            w_remaining_nxt = r_remaining - TIME_W'(1);
          end
        end
      end
    endcase

    // Abort overrides everything, including an expiry landing on the same edge.
    if (abort && (r_state != StIdle)) begin
      w_state_nxt     = StIdle;
      w_busy_nxt      = 1'b0;
      w_expired_nxt   = 1'b0;
      w_remaining_nxt = '0;
    end
  end

  assign interval  = r_interval;
  assign busy      = r_busy;
  assign expired   = r_expired;
  assign remaining = r_remaining;

endmodule
